xalu_seq: RTL and testbench

XALU_SEQ -- requirements
Module: xalu_seq

---
 rtl/xalu_seq.sv | 186 ++++++++++++++++++
 tb/tb_xalu_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/xalu_seq.sv
// Sequencer that runs 16-bit ALU operations through one external 4-bit slice, one nibble per cycle.
// Optional XALU_SEQ_FLAGS_EN builds the zero/equ flag logic; otherwise both flags are tied low.
module xalu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        com,
  input  logic        cin,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cout,
  output logic        zero,
  output logic        equ,
  output logic [3:0]  sl_a,
  output logic [3:0]  sl_b,
  output logic [2:0]  sl_f,
  output logic        sl_com,
  output logic        sl_ci_right,
  output logic        sl_ci_left,
  input  logic [3:0]  sl_d,
  input  logic        sl_co_left,
  input  logic        sl_co_right,
  input  logic        sl_equ
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  state_t      state_r;
  logic [1:0]  k_r;
  logic [15:0] a_r, b_r;
  logic [2:0]  op_r;
  logic        busy_r, done_r, cout_r;
  logic [15:0] result_r;
  logic [3:0]  sl_a_r, sl_b_r;
  logic [2:0]  sl_f_r;
  logic        sl_com_r, sl_ci_right_r, sl_ci_left_r;

  logic [1:0]  nib_idx_s, nxt_idx_s, k_nxt_s;
  logic [15:0] result_next_s;
  logic        chain_r_s, chain_l_s;

  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // Nibble order, carry-chain selection and the result with the current slice output merged in.
  always_comb begin
    k_nxt_s       = k_r + 2'd1;
    chain_r_s     = (op_r == OP_ADD) || (op_r == OP_SHL);
    chain_l_s     = (op_r == OP_SHR);
    result_next_s = result_r;
    if (chain_l_s) begin
      nib_idx_s = 2'd3 - k_r;
      nxt_idx_s = 2'd3 - k_nxt_s;
    end else begin
      nib_idx_s = k_r;
      nxt_idx_s = k_nxt_s;
    end
    result_next_s[{nib_idx_s, 2'b00} +: 4] = sl_d;
  end

  // Main sequencer: operand latch, slice drive, carry chaining and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      k_r           <= 2'd0;
      a_r           <= 16'h0000;
      b_r           <= 16'h0000;
      op_r          <= 3'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      cout_r        <= 1'b0;
      result_r      <= 16'h0000;
      sl_a_r        <= 4'h0;
      sl_b_r        <= 4'h0;
      sl_f_r        <= 3'd0;
      sl_com_r      <= 1'b0;
      sl_ci_right_r <= 1'b0;
      sl_ci_left_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r       <= RUN;
            busy_r        <= 1'b1;
            k_r           <= 2'd0;
            a_r           <= a;
            b_r           <= b;
            op_r          <= op;
            sl_a_r        <= nib(a, (op == OP_SHR) ? 2'd3 : 2'd0);
            sl_b_r        <= nib(b, (op == OP_SHR) ? 2'd3 : 2'd0);
            sl_f_r        <= op;
            sl_com_r      <= com;
            sl_ci_right_r <= ((op == OP_ADD) || (op == OP_SHL)) ? cin : 1'b0;
            sl_ci_left_r  <= (op == OP_SHR) ? cin : 1'b0;
          end
        end
        RUN: begin
          result_r <= result_next_s;
          k_r      <= k_nxt_s;
          if (k_r == 2'd3) begin
            state_r       <= DONE;
            done_r        <= 1'b1;
            cout_r        <= chain_r_s ? sl_co_left : (chain_l_s ? sl_co_right : 1'b0);
            sl_a_r        <= 4'h0;
            sl_b_r        <= 4'h0;
            sl_f_r        <= 3'd0;
            sl_com_r      <= 1'b0;
            sl_ci_right_r <= 1'b0;
            sl_ci_left_r  <= 1'b0;
          end else begin
            sl_a_r        <= nib(a_r, nxt_idx_s);
            sl_b_r        <= nib(b_r, nxt_idx_s);
            sl_ci_right_r <= chain_r_s ? sl_co_left : 1'b0;
            sl_ci_left_r  <= chain_l_s ? sl_co_right : 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef XALU_SEQ_FLAGS_EN
  logic zero_r, equ_r, equ_acc_r;

  // Flag accumulation: nibble equality is ANDed over the run, zero taken from the final word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_r    <= 1'b0;
      equ_r     <= 1'b0;
      equ_acc_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      equ_acc_r <= 1'b1;
    end else if (state_r == RUN) begin
      equ_acc_r <= equ_acc_r & sl_equ;
      if (k_r == 2'd3) begin
        zero_r <= (result_next_s == 16'h0000);
        equ_r  <= equ_acc_r & sl_equ;
      end
    end
  end

  assign zero = zero_r;
  assign equ  = equ_r;
`else
  assign zero = 1'b0;
  assign equ  = 1'b0;
`endif

  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;
  assign cout        = cout_r;
  assign sl_a        = sl_a_r;
  assign sl_b        = sl_b_r;
  assign sl_f        = sl_f_r;
  assign sl_com      = sl_com_r;
  assign sl_ci_right = sl_ci_right_r;
  assign sl_ci_left  = sl_ci_left_r;

endmodule

// File: tb/tb_xalu_seq.sv
// Directed bench for xalu_seq with a behavioural model of the external 4-bit slice.
module tb_xalu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic        com, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, zero, equ;
  logic [15:0] result;
  logic [3:0]  sl_a, sl_b, sl_d;
  logic [2:0]  sl_f;
  logic        sl_com, sl_ci_right, sl_ci_left;
  logic        sl_co_left, sl_co_right, sl_equ;

  int total = 0;
  int bad   = 0;
  int done_cnt;

  always #5 clk = ~clk;

  xalu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .com(com), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .cout(cout),
    .zero(zero), .equ(equ), .sl_a(sl_a), .sl_b(sl_b), .sl_f(sl_f),
    .sl_com(sl_com), .sl_ci_right(sl_ci_right), .sl_ci_left(sl_ci_left),
    .sl_d(sl_d), .sl_co_left(sl_co_left), .sl_co_right(sl_co_right), .sl_equ(sl_equ)
  );

  // External slice model
  always_comb begin
    logic [4:0] sum;
    logic [3:0] f;
    sum         = 5'd0;
    f           = 4'h0;
    sl_co_left  = 1'b0;
    sl_co_right = 1'b0;
    case (sl_f)
      3'd0: begin sum = {1'b0, sl_a} + {1'b0, sl_b} + {4'h0, sl_ci_right}; f = sum[3:0]; sl_co_left = sum[4]; end
      3'd1: f = sl_a & sl_b;
      3'd2: f = sl_a | sl_b;
      3'd3: f = sl_a ^ sl_b;
      3'd4: f = sl_a;
      3'd5: f = sl_b;
      3'd6: begin f = {sl_ci_left, sl_a[3:1]}; sl_co_right = sl_a[0]; end
      3'd7: begin f = {sl_a[2:0], sl_ci_right}; sl_co_left = sl_a[3]; end
      default: f = 4'h0;
    endcase
    sl_d   = sl_com ? ~f : f;
    sl_equ = (sl_a == sl_b);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one operation and check done timing (high only after the 4th edge following the start edge).
  task automatic run_op(input logic [2:0] o, input logic c, input logic ci,
                        input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    op = o; com = c; cin = ci; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~va; b = ~vb; op = 3'd2;
    check("busy_run", {15'd0, busy}, 16'd1);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("done_t%0d", i), {15'd0, done}, (i == 4) ? 16'd1 : 16'd0);
    end
    check("busy_idle", {15'd0, busy}, 16'd0);
  endtask

  task automatic check_out(input string tag, input logic [15:0] r, input logic co,
                           input logic z, input logic e);
    logic ez, ee;
`ifdef XALU_SEQ_FLAGS_EN
    ez = z; ee = e;
`else
    ez = 1'b0; ee = 1'b0;
`endif
    check({tag, "_result"}, result, r);
    check({tag, "_cout"}, {15'd0, cout}, {15'd0, co});
    check({tag, "_zero"}, {15'd0, zero}, {15'd0, ez});
    check({tag, "_equ"}, {15'd0, equ}, {15'd0, ee});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; com = 1'b0; cin = 1'b0; a = 16'h0; b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check_out("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    check("rst_sl_a", {12'd0, sl_a}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FCD);
    check_out("add", 16'h2201, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("add_hold", result, 16'h2201);

    run_op(3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    check_out("addwrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    // Back-to-back: next start lands in the IDLE cycle right after DONE.
    run_op(3'd7, 1'b0, 1'b1, 16'h8001, 16'h0000);
    check_out("shl", 16'h0003, 1'b1, 1'b0, 1'b0);
    run_op(3'd6, 1'b0, 1'b0, 16'h8001, 16'h0000);
    check_out("shr", 16'h4000, 1'b1, 1'b0, 1'b0);
    run_op(3'd3, 1'b1, 1'b0, 16'hAAAA, 16'hAAAA);
    check_out("xorc", 16'hFFFF, 1'b0, 1'b0, 1'b1);
    run_op(3'd1, 1'b0, 1'b1, 16'hF0F0, 16'h3C3C);
    check_out("and", 16'h3030, 1'b0, 1'b0, 1'b0);

    // Start re-pulsed during RUN with other operands.
    @(negedge clk);
    op = 3'd0; com = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h0FCD; start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'hFFFF; b = 16'h0001; op = 3'd7; cin = 1'b1;
    done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("rerun_done_cnt", done_cnt[15:0], 16'd1);
    check_out("rerun", 16'h2201, 1'b0, 1'b0, 1'b0);

    // Reset asserted in the second RUN cycle.
    @(negedge clk);
    op = 3'd0; com = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h0FCD; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("mid_sl_a", {12'd0, sl_a}, 16'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_busy", {15'd0, busy}, 16'd0);
    check("mid_sl_a0", {12'd0, sl_a}, 16'd0);
    check("mid_sl_ci", {15'd0, sl_ci_right}, 16'd0);
    check_out("mid", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_cnt++;
    end
    check("mid_no_done", done_cnt[15:0], 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
